// File: rtl/text_buffer_writer_pkg.sv
// rtl/text_buffer_writer_pkg.sv - shared geometry, control codes and state encoding for the text buffer
package text_buffer_writer_pkg;

   localparam int WIDTH_IN_CHARS          = 21;
   localparam int HEIGHT_IN_CHARS         = 12;
   localparam int MAXIMUM_NUMBER_OF_CHARS = WIDTH_IN_CHARS * HEIGHT_IN_CHARS;

   localparam logic [7:0] COLS_B    = 8'(WIDTH_IN_CHARS);
   localparam logic [7:0] DEPTH_B   = 8'(MAXIMUM_NUMBER_OF_CHARS);
   localparam logic [7:0] LAST_ADDR = 8'(MAXIMUM_NUMBER_OF_CHARS - 1);
   localparam logic [7:0] LAST_K    = 8'(WIDTH_IN_CHARS - 1);
   localparam logic [4:0] LAST_COL  = 5'(WIDTH_IN_CHARS - 1);
   localparam logic [3:0] LAST_ROW  = 4'(HEIGHT_IN_CHARS - 1);

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_RUN    = 2'd1,
      ST_ROWCLR = 2'd2
   } state_t;

   // Start address of a row; the largest result (11*21) stays inside 8 bits.
   function automatic logic [7:0] row_base(input logic [3:0] row);
      return 8'(row) * COLS_B;
   endfunction

endpackage

// File: rtl/char_ram.sv
// rtl/char_ram.sv - character storage: one write port, one registered read port, contents not reset
module char_ram
   import text_buffer_writer_pkg::*;
(
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [0:MAXIMUM_NUMBER_OF_CHARS-1];

   always_ff @(posedge iVGA_CLK) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Out-of-range addresses read as blank; same-address write returns the old byte.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n)
         rd_data <= 8'h00;
      else if (rd_addr < DEPTH_B)
         rd_data <= mem[rd_addr];
      else
         rd_data <= 8'h00;
   end

endmodule

// File: rtl/text_buffer_writer.sv
// rtl/text_buffer_writer.sv - byte stream to character RAM with cursor, control codes and row clearing
module text_buffer_writer
   import text_buffer_writer_pkg::*;
(
   input  logic       iVGA_CLK,
   input  logic       iRST_n,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   output logic       in_ready,
   input  logic       clear_req,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [4:0] cursor_col,
   output logic [3:0] cursor_row,
   output logic       busy
);

   state_t     state;
   logic [7:0] ptr;
   logic       accept;
   logic       printable;
   logic [7:0] row_addr;
   logic       we;
   logic [7:0] waddr;
   logic [7:0] wdata;

   assign in_ready  = (state == ST_RUN) && !clear_req;
   assign accept    = in_valid && in_ready;
   assign busy      = (state != ST_RUN);
   assign printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
   assign row_addr  = row_base(cursor_row);

   // Write port is shared between the sweep pointer and the cursor.
   always_comb begin
      we    = 1'b0;
      waddr = ptr;
      wdata = 8'h00;
      case (state)
         ST_CLEAR: begin
            we    = 1'b1;
            waddr = ptr;
         end
         ST_ROWCLR: begin
            we    = 1'b1;
            waddr = row_addr + ptr;
         end
         ST_RUN: begin
            if (accept && printable) begin
               we    = 1'b1;
               waddr = row_addr + {3'b000, cursor_col};
               wdata = in_char;
            end else if (accept && in_char == CH_BS && cursor_col != 5'd0) begin
               we    = 1'b1;
               waddr = row_addr + {3'b000, cursor_col - 5'd1};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state      <= ST_CLEAR;
         ptr        <= 8'd0;
         cursor_col <= 5'd0;
         cursor_row <= 4'd0;
      end else if (clear_req || (accept && in_char == CH_FF)) begin
         state      <= ST_CLEAR;
         ptr        <= 8'd0;
         cursor_col <= 5'd0;
         cursor_row <= 4'd0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (ptr == LAST_ADDR) begin
                  state <= ST_RUN;
                  ptr   <= 8'd0;
               end else begin
                  ptr <= ptr + 8'd1;
               end
            end
            ST_ROWCLR: begin
               if (ptr == LAST_K) begin
                  state <= ST_RUN;
                  ptr   <= 8'd0;
               end else begin
                  ptr <= ptr + 8'd1;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  // A full row and a line feed both move to a fresh, cleared row.
                  if ((printable && cursor_col == LAST_COL) || in_char == CH_LF) begin
                     cursor_col <= 5'd0;
                     cursor_row <= (cursor_row == LAST_ROW) ? 4'd0 : cursor_row + 4'd1;
                     state      <= ST_ROWCLR;
                     ptr        <= 8'd0;
                  end else if (printable) begin
                     cursor_col <= cursor_col + 5'd1;
                  end else if (in_char == CH_CR) begin
                     cursor_col <= 5'd0;
                  end else if (in_char == CH_BS && cursor_col != 5'd0) begin
                     cursor_col <= cursor_col - 5'd1;
                  end
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   char_ram u_char_ram (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

endmodule
